// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field layout, constants and operand classification
package fpu_pkg;

    localparam int          FP_EXP_W     = 8;
    localparam int          FP_FRAC_W    = 23;
    localparam int          EXP_BIAS     = 127;
    localparam int          EXP_MAX      = 255;
    localparam logic [31:0] QNAN_DEFAULT = 32'hFFC0_0000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_NORM,
        FP_ZERO,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Exponent 0 counts as zero: denormals are flushed.
    function automatic fp_class_e fp_classify(input fp32_t v);
        fp_class_e c;
        if (v.exp == '1) begin
            c = (v.frac != '0) ? FP_NAN : FP_INF;
        end else if (v.exp == '0) begin
            c = FP_ZERO;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fdiv_step.sv
// rtl/fdiv_step.sv - one combinational radix-2 restoring division step
module fdiv_step #(
    parameter int W = 26
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] two_r;
    logic [W:0] diff;

    always_comb begin
        two_r = {rem_i, 1'b0};
        diff  = two_r - {1'b0, div_i};
        q_o   = (two_r >= {1'b0, div_i});
        rem_o = q_o ? diff[W-1:0] : two_r[W-1:0];
    end

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - multi-cycle FP32 divider, RNE, valid/ready on both sides.
// Define FDIV_EARLY_OUT_EN to let special operands bypass the iteration phase.
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int BPC   = 1,
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz
);

    localparam int ITER_CYC = QBITS / BPC;

    if (!(BPC == 1 || BPC == 2)) begin : g_bad_bpc
        $error("fdiv_iter: BPC must be 1 or 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;

    state_e             state_q, state_d;
    fp32_t              x1_q, x1_d, x2_q, x2_d;
    logic [QBITS-1:0]   rem_q, rem_d, div_q, div_d, quo_q, quo_d;
    logic signed [9:0]  ex_q, ex_d;
    logic               sign_q, sign_d;
    logic               spc_q, spc_d, spc_dz_q, spc_dz_d;
    logic [31:0]        spc_y_q, spc_y_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d, dz_q, dz_d;

    // Restoring step chain: BPC steps per ITER cycle, first step yields the MSB.
    logic [QBITS-1:0]   rem_c [0:BPC];
    logic [BPC-1:0]     qb;

    assign rem_c[0] = rem_q;
    for (genvar i = 0; i < BPC; i++) begin : g_step
        fdiv_step #(.W(QBITS)) u_step (
            .rem_i (rem_c[i]),
            .div_i (div_q),
            .rem_o (rem_c[i+1]),
            .q_o   (qb[BPC-1-i])
        );
    end

    fp_class_e          ca, cb;
    logic [23:0]        m1, m2;
    logic               m_lt, sgn;
    logic               sticky, up, carry;
    logic [22:0]        frac_r;
    logic signed [9:0]  ex_r;

    always_comb begin
        ca     = fp_classify(x1_q);
        cb     = fp_classify(x2_q);
        m1     = {1'b1, x1_q.frac};
        m2     = {1'b1, x2_q.frac};
        m_lt   = (m1 < m2);
        sgn    = x1_q.sign ^ x2_q.sign;
        // Quotient is 1.xxx with 23 fraction bits, then guard [1] and round [0].
        sticky = |rem_q;
        up     = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
        carry  = (&quo_q[QBITS-1:2]) & up;
        frac_r = quo_q[QBITS-2:2] + {22'd0, up};
        ex_r   = ex_q + {9'd0, carry};
    end

    always_comb begin
        state_d     = state_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        ex_d        = ex_q;
        sign_d      = sign_q;
        spc_d       = spc_q;
        spc_dz_d    = spc_dz_q;
        spc_y_d     = spc_y_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x1_d       = x1;
                    x2_d       = x2;
                    in_ready_d = 1'b0;
                    state_d    = S_PREP;
                end
            end
            S_PREP: begin
                // Dividend pre-shifted so the 26-bit quotient always lands in [2^25, 2^26).
                rem_d    = m_lt ? {1'b0, m1, 1'b0} : {2'b00, m1};
                div_d    = {1'b0, m2, 1'b0};
                quo_d    = '0;
                ex_d     = {2'b00, x1_q.exp} - {2'b00, x2_q.exp} + 10'(EXP_BIAS) - {9'd0, m_lt};
                sign_d   = sgn;
                cnt_d    = 5'(ITER_CYC - 1);
                spc_d    = 1'b1;
                spc_dz_d = 1'b0;
                spc_y_d  = '0;
                if (ca == FP_NAN) begin
                    spc_y_d = x1_q | 32'h0040_0000;
                end else if (cb == FP_NAN) begin
                    spc_y_d = x2_q | 32'h0040_0000;
                end else if ((ca == FP_INF && cb == FP_INF) || (ca == FP_ZERO && cb == FP_ZERO)) begin
                    spc_y_d = QNAN_DEFAULT;
                end else if (ca == FP_INF) begin
                    spc_y_d = {sgn, 8'hFF, 23'd0};
                end else if (cb == FP_INF || ca == FP_ZERO) begin
                    spc_y_d = {sgn, 31'd0};
                end else if (cb == FP_ZERO) begin
                    spc_y_d  = {sgn, 8'hFF, 23'd0};
                    spc_dz_d = 1'b1;
                end else begin
                    spc_d = 1'b0;
                end
                state_d = S_ITER;
`ifdef FDIV_EARLY_OUT_EN
                if (ca != FP_NORM || cb != FP_NORM) begin
                    state_d = S_ROUND;
                end
`endif
            end
            S_ITER: begin
                rem_d = rem_c[BPC];
                quo_d = {quo_q[QBITS-BPC-1:0], qb};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                ovf_d = 1'b0;
                dz_d  = 1'b0;
                if (spc_q) begin
                    y_d  = spc_y_q;
                    dz_d = spc_dz_q;
                end else if (ex_r >= EXP_MAX) begin
                    y_d   = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else if (ex_r <= 0) begin
                    y_d = {sign_q, 31'd0};
                end else begin
                    y_d = {sign_q, ex_r[7:0], frac_r};
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    dz_d        = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            x1_q        <= '0;
            x2_q        <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            ex_q        <= '0;
            sign_q      <= 1'b0;
            spc_q       <= 1'b0;
            spc_dz_q    <= 1'b0;
            spc_y_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            ex_q        <= ex_d;
            sign_q      <= sign_d;
            spc_q       <= spc_d;
            spc_dz_q    <= spc_dz_d;
            spc_y_q     <= spc_y_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - scoreboard bench for fdiv_iter
module tb_fdiv_iter;

    parameter int BPC      = 1;
    localparam int QBITS    = 26;
    localparam int LAT_FULL = QBITS / BPC + 2;
    localparam int N_RAND   = 1500;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic        dz;

    fdiv_iter #(.BPC(BPC), .QBITS(QBITS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
        logic        dz;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output res_t r, output bit spc);
        logic            sa, sb, s;
        logic [7:0]      ea, eb;
        logic [22:0]     fa, fb;
        longint unsigned ma, mb, num, q, rem, sig;
        int              e;
        bit              g, st, up;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        s   = sa ^ sb;
        r   = '0;
        spc = 1'b1;
        if (ea == 8'hFF && fa != 0)                                  r.y = a | 32'h0040_0000;
        else if (eb == 8'hFF && fb != 0)                             r.y = b | 32'h0040_0000;
        else if ((ea == 8'hFF && eb == 8'hFF) || (ea == 0 && eb == 0)) r.y = 32'hFFC0_0000;
        else if (ea == 8'hFF)                                        r.y = {s, 8'hFF, 23'd0};
        else if (eb == 8'hFF)                                        r.y = {s, 31'd0};
        else if (ea == 0)                                            r.y = {s, 31'd0};
        else if (eb == 0) begin
            r.y  = {s, 8'hFF, 23'd0};
            r.dz = 1'b1;
        end else begin
            spc = 1'b0;
            ma  = {40'd0, 1'b1, fa};
            mb  = {40'd0, 1'b1, fb};
            num = ma << 26;
            q   = num / mb;
            rem = num % mb;
            e   = int'(ea) - int'(eb) + 127;
            if (q >= (64'd1 << 26)) begin
                sig = q >> 3;
                g   = q[2];
                st  = (q[1:0] != 0) || (rem != 0);
            end else begin
                sig = q >> 2;
                g   = q[1];
                st  = q[0] || (rem != 0);
                e   = e - 1;
            end
            up  = g && (st || sig[0]);
            sig = sig + {63'd0, up};
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e   = e + 1;
            end
            if (e >= 255) begin
                r.y   = {s, 8'hFF, 23'd0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.y = {s, 31'd0};
            end else begin
                r.y = {s, e[7:0], sig[22:0]};
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input res_t want,
                          input bit spc, input bit hold);
        int          lat;
        int          edges;
        res_t        exp_r;
        logic [31:0] y_held;
        exp_q.push_back(want);
        lat = LAT_FULL;
`ifdef FDIV_EARLY_OUT_EN
        if (spc) lat = 2;
`else
        if (spc) lat = LAT_FULL;
`endif
        @(negedge clk);
        x1       = a;
        x2       = b;
        in_valid = 1'b1;
        edges    = 0;
        while (!in_ready && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(lat));
        exp_r = exp_q.pop_front();
        if (out_valid) begin
            check("y", 64'(y), 64'(exp_r.y));
            check("ovf", 64'(ovf), 64'(exp_r.ovf));
            check("dz", 64'(dz), 64'(exp_r.dz));
        end
        if (hold) begin
            y_held = y;
            repeat (5) begin
                @(negedge clk);
                in_valid = 1'b1;
                x1       = $urandom;
                x2       = $urandom;
                @(posedge clk);
                #1;
                check("hold_y", 64'(y), 64'(y_held));
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_out_valid", 64'(out_valid), 64'd1);
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("handoff_out_valid", 64'(out_valid), 64'd0);
        check("handoff_in_ready", 64'(in_ready), 64'd1);
        check("handoff_flags", 64'({ovf, dz}), 64'd0);
    endtask

    task automatic run_rand(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        bit   spc;
        ref_div(a, b, r, spc);
        run_op(a, b, r, spc, 1'b0);
    endtask

    function automatic logic [31:0] rand_normal();
        logic [7:0] e;
        if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(1, 254));
        else                           e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
        bit          spc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = '0;
        x2        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_flags", 64'({ovf, dz}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        vecs.push_back('{32'h40C0_0000, 32'h4000_0000, '{32'h4040_0000, 1'b0, 1'b0}, 1'b0});
        vecs.push_back('{32'h3F80_0000, 32'h4040_0000, '{32'h3EAA_AAAB, 1'b0, 1'b0}, 1'b0});
        vecs.push_back('{32'hBF80_0000, 32'h4040_0000, '{32'hBEAA_AAAB, 1'b0, 1'b0}, 1'b0});
        vecs.push_back('{32'h3F80_0000, 32'h0000_0000, '{32'h7F80_0000, 1'b0, 1'b1}, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, '{32'hFFC0_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h7F80_0000, 32'hFF80_0000, '{32'hFFC0_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, '{32'h7FC0_0001, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h3F80_0000, 32'h7FA0_0000, '{32'h7FE0_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'hFF80_0000, 32'h3F80_0000, '{32'hFF80_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h3F80_0000, 32'hFF80_0000, '{32'h8000_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h3F80_0000, '{32'h8000_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, '{32'h0000_0000, 1'b0, 1'b0}, 1'b1});
        vecs.push_back('{32'h7F00_0000, 32'h3F00_0000, '{32'h7F80_0000, 1'b1, 1'b0}, 1'b0});
        vecs.push_back('{32'h0080_0000, 32'hC000_0000, '{32'h8000_0000, 1'b0, 1'b0}, 1'b0});
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, '{32'h3F80_0000, 1'b0, 1'b0}, 1'b0});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].spc, i == 0);
        end

        // Abort mid-iteration: the job must vanish and the next op must be clean.
        @(negedge clk);
        x1       = 32'h4120_0000;
        x2       = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_y", 64'(y), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(32'h40C0_0000, 32'h4000_0000, '{32'h4040_0000, 1'b0, 1'b0}, 1'b0, 1'b0);

        for (int i = 0; i < N_RAND; i++) begin
            run_rand(rand_normal(), rand_normal());
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
